// File: rtl/regfile_wr_arb.sv
// Register file with one core writeback port and two round-robin arbitrated
// execution-unit write ports; two combinational read ports.
module regfile_wr_arb #(
    parameter int data_width = 32,
    parameter int num_regs = 32,
    localparam int reg_sel_width = $clog2(num_regs)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_en,
    input  logic [reg_sel_width-1:0] wb_sel,
    input  logic [data_width-1:0]    wb_data,
    input  logic [1:0]               rf_wr_req,
    input  logic [reg_sel_width-1:0] rf_wr_sel [2],
    input  logic [data_width-1:0]    rf_wr_data [2],
    output logic [1:0]               rf_wr_ack,
    input  logic [reg_sel_width-1:0] rd_sel [2],
    output logic [data_width-1:0]    rd_data [2]
);

    logic [data_width-1:0]    regs [num_regs];
    logic                     last_grant;
    logic [1:0]               eligible;
    logic                     gnt_valid;
    logic                     gnt_port;
    logic                     wr_en;
    logic [reg_sel_width-1:0] wr_sel;
    logic [data_width-1:0]    wr_data;

    function automatic logic in_range(input logic [reg_sel_width-1:0] s);
        return 32'(s) < num_regs;
    endfunction

    // A port in its ack cycle still shows the old request, so it is masked out.
    assign eligible = rf_wr_req & ~rf_wr_ack;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (!wb_en) begin
            if (eligible == 2'b11) begin
                gnt_valid = 1'b1;
                gnt_port  = ~last_grant;
            end else if (eligible[0]) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b0;
            end else if (eligible[1]) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b1;
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        if (wb_en) begin
            wr_sel  = wb_sel;
            wr_data = wb_data;
        end else if (gnt_valid) begin
            wr_sel  = rf_wr_sel[gnt_port];
            wr_data = rf_wr_data[gnt_port];
        end
        // Register 0 and out-of-range targets are silently dropped.
        if ((wb_en || gnt_valid) && wr_sel != '0 && in_range(wr_sel))
            wr_en = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_regs; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_sel] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_ack  <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            rf_wr_ack <= 2'b00;
            if (gnt_valid) begin
                rf_wr_ack[gnt_port] <= 1'b1;
                last_grant          <= gnt_port;
            end
        end
    end

    always_comb begin
        for (int q = 0; q < 2; q++)
            rd_data[q] = in_range(rd_sel[q]) ? regs[rd_sel[q]] : '0;
    end

    a_inputs_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({wb_en, wb_sel, wb_data, rf_wr_req,
                     rf_wr_sel[0], rf_wr_sel[1], rf_wr_data[0], rf_wr_data[1],
                     rd_sel[0], rd_sel[1]}));

    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        rf_wr_ack != 2'b11);

endmodule
